// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester handshake and the uart_tx control signals used by
//   uart_tx_arbiter.
//
// Signals:
//   req_valid [NUM_REQ]    per-requester byte valid
//   req_data  [8*NUM_REQ]  per-requester byte, requester i on [8i+7:8i]
//   req_ready [NUM_REQ]    one-hot accept from the arbiter
//   tx_start               one-cycle start pulse to uart_tx
//   tx_data   [8]          byte to uart_tx
//   tx_busy                busy flag from uart_tx
//   grant_id  [ID_W]       requester owning the current frame
//   arb_busy               arbiter not idle
//   fault                  sticky busy-timeout flag
//
// Modports:
//   slave  - the arbiter side
//   master - the requesters / uart_tx side (testbench)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 arb_busy;
  logic                 fault;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, arb_busy, fault
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, arb_busy, fault
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx serializer among NUM_REQ byte producers with
//   round-robin arbitration. A byte is accepted from the winner by a
//   valid/ready handshake, a one-cycle tx_start is issued with tx_data, and
//   tx_busy is tracked until the frame completes. If tx_busy fails to rise
//   within BUSY_TIMEOUT cycles of tx_start, the sticky fault flag is set and
//   the byte is dropped.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    uart_tx_arbiter_if.slave (requester handshake + uart_tx control)
//
// Optional feature (macro UART_TX_ARB_TAG_EN):
//   Each grant sends a tag byte {4'hA, grant_id} followed by the data byte.
//   The data byte is parked in a hold register until the tag frame is done.
//   A timeout on either frame drops both.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_grant_id;
  logic [7:0]      r_tx_data;
  logic [CNT_W-1:0] r_cnt;
  logic            r_fault;

  logic [ID_W-1:0] w_winner;
  logic            w_any_valid;
  logic            w_accept;
  logic            w_timeout;
  int              w_idx;

`ifdef UART_TX_ARB_TAG_EN
  logic            r_tag_phase;
  logic [7:0]      r_data_hold;
`endif

  // Round-robin search: first valid index at or after the pointer, wrapping.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_any_valid && bus.req_valid[w_idx]) begin
        w_any_valid = 1'b1;
        w_winner    = ID_W'(w_idx);
      end
    end
  end

  // Grants only from IDLE with the serializer free; reset masks the
  // combinational ready so it reads 0 while reset is held.
  assign w_accept      = (r_state == S_IDLE) && !bus.tx_busy && w_any_valid && !reset;
  assign bus.req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
  assign bus.tx_start  = (r_state == S_ISSUE);
  assign bus.arb_busy  = (r_state != S_IDLE);
  assign bus.tx_data   = r_tx_data;
  assign bus.grant_id  = r_grant_id;
  assign bus.fault     = r_fault;

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // This is the BUSY_TIMEOUT-th cycle spent waiting.
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
`ifdef UART_TX_ARB_TAG_EN
          w_next_state = r_tag_phase ? S_ISSUE : S_IDLE;
`else
          w_next_state = S_IDLE;
`endif
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_tx_data   <= 8'h00;
      r_cnt       <= '0;
      r_fault     <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      r_tag_phase <= 1'b0;
      r_data_hold <= 8'h00;
`endif
    end else begin
      if (w_accept) begin
        r_grant_id <= w_winner;
        r_ptr      <= (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;
`ifdef UART_TX_ARB_TAG_EN
        r_tx_data   <= {4'hA, 4'(w_winner)};
        r_data_hold <= bus.req_data[8*w_winner +: 8];
        r_tag_phase <= 1'b1;
`else
        r_tx_data  <= bus.req_data[8*w_winner +: 8];
`endif
      end

      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (r_state == S_WAIT_BUSY && !bus.tx_busy) r_cnt <= r_cnt + 1'b1;

      if (w_timeout) r_fault <= 1'b1;

`ifdef UART_TX_ARB_TAG_EN
      // Tag frame done: swap in the parked data byte for the second pass.
      if (r_state == S_WAIT_DONE && !bus.tx_busy && r_tag_phase) begin
        r_tx_data   <= r_data_hold;
        r_tag_phase <= 1'b0;
      end
      if (w_timeout) r_tag_phase <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed testbench for uart_tx_arbiter. The bench plays both the byte
//   requesters and uart_tx (driving tx_busy and capturing tx_data at each
//   tx_start). Honours UART_TX_ARB_TAG_EN when defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int BUSY_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_if ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  // Advance one cycle; observe 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] data);
    u_if.req_valid[idx]       = 1'b1;
    u_if.req_data[8*idx +: 8] = data;
  endtask

  // Called in the ISSUE cycle: checks the start pulse and the frame owner.
  task automatic check_issue(input int idx, input logic [7:0] exp_data, input string name);
    logic [12+NUM_REQ-1:0] got, exp;
    got = {u_if.tx_start, u_if.arb_busy, u_if.grant_id, u_if.tx_data, u_if.req_ready};
    exp = {1'b1, 1'b1, ID_W'(idx), exp_data, {NUM_REQ{1'b0}}};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s issue: {start,busy,gid,data,ready}=%h required %h", name, got, exp);
    end
  endtask

  // Emulates uart_tx for one frame, starting in the ISSUE cycle.
  task automatic serve_frame(input logic [7:0] exp_data, input string name);
    step();
    checks++;
    if (u_if.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL %s start_pulse: tx_start=%b required 0", name, u_if.tx_start);
    end
    u_if.tx_busy = 1'b1;
    repeat (3) step();
    checks++;
    if (u_if.tx_data !== exp_data) begin
      errors++;
      $display("FAIL %s data_hold: tx_data=%h required %h", name, u_if.tx_data, exp_data);
    end
    u_if.tx_busy = 1'b0;
    step();
  endtask

  // From the ISSUE cycle: tag frame (if enabled) then data frame.
  task automatic finish_grant(input int idx, input logic [7:0] data, input string name);
`ifdef UART_TX_ARB_TAG_EN
    check_issue(idx, {4'hA, 4'(idx)}, {name, "_tag"});
    serve_frame({4'hA, 4'(idx)}, {name, "_tag"});
`endif
    check_issue(idx, data, name);
    serve_frame(data, name);
  endtask

  // In IDLE with requests posted: expect one-hot ready to idx, accept, serve.
  task automatic do_grant(input int idx, input logic [7:0] data, input string name);
    #1;
    checks++;
    if (u_if.req_ready !== NUM_REQ'(1 << idx)) begin
      errors++;
      $display("FAIL %s ready: req_ready=%b required %b", name, u_if.req_ready, NUM_REQ'(1 << idx));
    end
    step();
    u_if.req_valid[idx] = 1'b0;
    finish_grant(idx, data, name);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    logic [13+NUM_REQ-1:0] got;
    got = {u_if.req_ready, u_if.tx_start, u_if.tx_data, u_if.grant_id, u_if.arb_busy, u_if.fault};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s reset_values: {ready,start,data,gid,busy,fault}=%h required 0", name, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    check_reset_values("reset");
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_req(1, 8'h55);
    do_grant(1, 8'h55, "single");
    checks++;
    if (u_if.arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL single idle_after: arb_busy=%b required 0", u_if.arb_busy);
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    set_req(0, 8'h10);
    set_req(1, 8'h21);
    set_req(2, 8'h32);
    set_req(3, 8'h43);
    do_grant(0, 8'h10, "all_r0");
    do_grant(1, 8'h21, "all_r1");
    do_grant(2, 8'h32, "all_r2");
    do_grant(3, 8'h43, "all_r3");
  endtask

  task automatic test_fairness();
    set_req(2, 8'h62);
    do_grant(2, 8'h62, "fair_r2");
    set_req(0, 8'h70);
    set_req(3, 8'h73);
    do_grant(3, 8'h73, "fair_r3");
    do_grant(0, 8'h70, "fair_r0");
  endtask

  task automatic test_busy_block();
    u_if.tx_busy = 1'b1;
    set_req(0, 8'h0B);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({u_if.req_ready, u_if.tx_start, u_if.arb_busy} !== '0) begin
        errors++;
        $display("FAIL busy_block cycle%0d: {ready,start,busy}=%b required 0", c,
                 {u_if.req_ready, u_if.tx_start, u_if.arb_busy});
      end
      step();
    end
    u_if.tx_busy = 1'b0;
    do_grant(0, 8'h0B, "busy_release");
  endtask

  task automatic test_timeout();
    logic [7:0] first;
`ifdef UART_TX_ARB_TAG_EN
    first = {4'hA, 4'd1};
`else
    first = 8'h5A;
`endif
    set_req(1, 8'h5A);
    #1;
    checks++;
    if (u_if.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL timeout ready: req_ready=%b required 0010", u_if.req_ready);
    end
    step();
    u_if.req_valid[1] = 1'b0;
    check_issue(1, first, "timeout");
    repeat (BUSY_TIMEOUT) step();
    checks++;
    if ({u_if.fault, u_if.arb_busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout early: {fault,arb_busy}=%b required 01", {u_if.fault, u_if.arb_busy});
    end
    step();
    checks++;
    if ({u_if.fault, u_if.arb_busy, u_if.tx_start} !== 3'b100) begin
      errors++;
      $display("FAIL timeout expire: {fault,arb_busy,start}=%b required 100",
               {u_if.fault, u_if.arb_busy, u_if.tx_start});
    end
    set_req(2, 8'h77);
    do_grant(2, 8'h77, "after_fault");
    checks++;
    if (u_if.fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout sticky: fault=%b required 1", u_if.fault);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_req(0, 8'hA5);
    #1;
    checks++;
    if (u_if.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset ready: req_ready=%b required 0001", u_if.req_ready);
    end
    step();
    u_if.req_valid[0] = 1'b0;
    step();
    u_if.tx_busy = 1'b1;
    step();
    step();
    // Another requester is pending while reset is applied.
    set_req(3, 8'h33);
    reset = 1'b1;
    step();
    u_if.tx_busy = 1'b0;
    check_reset_values("midreset");
    u_if.req_valid[3] = 1'b0;
    reset = 1'b0;
    set_req(0, 8'hFF);
    do_grant(0, 8'hFF, "after_reset");
  endtask

`ifdef UART_TX_ARB_TAG_EN
  task automatic test_tag();
    set_req(2, 8'h3C);
    do_grant(2, 8'h3C, "tag_r2");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    u_if.req_valid = '0;
    u_if.req_data  = '0;
    u_if.tx_busy   = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_busy_block();
    test_timeout();
    test_reset_mid_frame();
`ifdef UART_TX_ARB_TAG_EN
    test_tag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among NUM_REQ byte producers using round-robin arbitration.
- Accepts a byte from the granted requester through a valid/ready handshake, issues a one-cycle tx_start with tx_data, then tracks tx_busy until the frame completes.
- Sits between the on-chip byte sources and uart_tx. The uart_rx loopback stays the checker on the bench.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_start before declaring a fault.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when valid&ready are both high in the same cycle
- tx_start  output  1  one-cycle start pulse to uart_tx
- tx_data  output  8  byte to uart_tx; held stable from tx_start until tx_busy falls
- tx_busy  input  1  busy flag from uart_tx
- grant_id  output  ID_W  requester that owns the current frame
- arb_busy  output  1  high in every state except IDLE
- fault  output  1  sticky; set on BUSY_TIMEOUT expiry, cleared only by reset

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, arb_busy=0, fault=0. Round-robin pointer=0, so requester 0 has top priority. State=IDLE.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any req_valid is set, req_ready is asserted combinationally, one-hot, to the winner.
  - The winner is the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - On the accept edge: tx_data<=req_data[winner], grant_id<=winner, pointer<=winner+1 (wrap), go to ISSUE.
  - If tx_busy=1 in IDLE, req_ready stays 0 and no grant is made.
- ISSUE: tx_start=1 for exactly one cycle, then WAIT_BUSY. Latency is accept cycle N to tx_start high in cycle N+1.
- WAIT_BUSY:
  - When tx_busy=1, go to WAIT_DONE.
  - A counter increments each cycle. When it reaches BUSY_TIMEOUT, set fault and return to IDLE; the byte is dropped.
- WAIT_DONE: when tx_busy=0, return to IDLE. A new grant is possible on the following cycle, giving one idle cycle minimum between frames.
- req_ready is 0 in all states except IDLE. Requesters must hold req_valid and req_data until accepted. Dropping valid before accept is legal and withdraws the request.
- Only one requester holds a grant at a time. Any requester that is valid in IDLE is granted within NUM_REQ grants.
- Reset mid-frame:
  - All state returns to reset values in the next cycle and the in-flight byte is abandoned.
  - uart_tx is reset by the same signal, so the line returns to idle.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- When defined:
  - Each grant sends two frames: first a tag byte {4'hA, 4'(grant_id)}, then the data byte.
  - An extra ISSUE/WAIT_BUSY/WAIT_DONE pass runs between the two frames.
  - The data byte is captured at accept and held internally until the tag frame completes.
  - grant_id and arb_busy stay asserted across both frames.
  - A timeout on either frame sets fault and drops both frames.
- When undefined: one frame per grant exactly as above, with no tag logic synthesized.

Test Plan:
1. Single requester: req 1 sends 8'h55 → req_ready[1] pulses once, tx_start one cycle later, grant_id=1, loopback rx_data=8'h55 with rx_error=0.
2. All four valid together with bytes 8'h10/8'h21/8'h32/8'h43 after reset → frames received in order 10,21,32,43, each accept one-hot.
3. Fairness: last grant went to req 2, then req 0 and req 3 request together → req 3 is served first, then req 0.
4. tx_busy forced high in IDLE with req 0 valid → req_ready stays 0 and tx_start stays 0 until tx_busy is released; grant follows within 1 cycle of release.
5. tx_busy held low after tx_start → fault=1 after exactly BUSY_TIMEOUT cycles in WAIT_BUSY, arb_busy=0, and the next request is still served.
6. Reset asserted mid-frame while sending 8'hA5, then 8'hFF sent → all outputs at reset values the cycle after reset; 8'hFF received intact. With UART_TX_ARB_TAG_EN, req 2 sending 8'h3C yields bytes 8'hA2 then 8'h3C.
